amplitude_detector_mc: RTL and testbench

Multi-channel, windowed peak-to-peak amplitude detector; successor to the single-pair max-only detector in the IAGC datapath.
Tracks the per-channel signed max and min over a runtime-programmable number of sample strobes, then publishes half the peak-to-peak value per channel with a one-cycle update strobe.
Sits between the ADC AXIS capture and the gain-control loop; window length and channel count are no longer fixed.

---
 rtl/amplitude_detector_mc.sv | 182 ++++++++++++++++++
 tb/tb_amplitude_detector_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/amplitude_detector_mc.sv
// Multi-channel windowed peak-to-peak amplitude detector: publishes (max - min) / 2 per channel.
// Optional macro AMPLITUDE_DETECTOR_SATURATION_FLAG_EN adds the o_saturated per-channel flags.
module amplitude_detector_mc #(
    parameter int unsigned CHANNELS            = 2,
    parameter int unsigned SLOT_SIZE           = 16,
    parameter int unsigned SAMPLE_SIZE         = 14,
    parameter int unsigned AMPLITUDE_DATA_SIZE = 16,
    parameter int unsigned COUNT_SIZE          = 16
) (
    input  logic                                    i_clock,
    input  logic                                    i_reset,
    input  logic                                    i_enable,
    input  logic                                    i_sample,
    input  logic [COUNT_SIZE-1:0]                   i_windowLength,
    input  logic [CHANNELS*SLOT_SIZE-1:0]           i_data,
    output logic [CHANNELS*AMPLITUDE_DATA_SIZE-1:0] o_amplitude,
    output logic                                    o_update,
    output logic                                    o_busy
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
    ,
    output logic [CHANNELS-1:0]                     o_saturated
`endif
);

    localparam logic signed [SAMPLE_SIZE-1:0] SampleMax = {1'b0, {(SAMPLE_SIZE-1){1'b1}}};
    localparam logic signed [SAMPLE_SIZE-1:0] SampleMin = {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
    localparam int unsigned DropBits = SLOT_SIZE - SAMPLE_SIZE;

    typedef enum logic [1:0] {StIdle, StSample, StDetect, StUpdate} state_e;

    state_e                                  state_q, state_d;
    logic [COUNT_SIZE-1:0]                   len_q, len_d;
    logic [COUNT_SIZE-1:0]                   count_q, count_d;
    logic [COUNT_SIZE-1:0]                   len_in;
    logic signed [SAMPLE_SIZE-1:0]           max_q [CHANNELS];
    logic signed [SAMPLE_SIZE-1:0]           max_d [CHANNELS];
    logic signed [SAMPLE_SIZE-1:0]           min_q [CHANNELS];
    logic signed [SAMPLE_SIZE-1:0]           min_d [CHANNELS];
    logic signed [SAMPLE_SIZE-1:0]           samp  [CHANNELS];
    logic [SAMPLE_SIZE:0]                    diff  [CHANNELS];
    logic [CHANNELS*AMPLITUDE_DATA_SIZE-1:0] amp_q, amp_d;
    logic                                    start_win;
    logic                                    accept;
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
    logic [CHANNELS-1:0]                     sat_acc_q, sat_acc_d;
    logic [CHANNELS-1:0]                     sat_q, sat_d;
`endif

    // Samples are MSB-aligned in their slot; the low slot bits carry no information.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign samp[k] = i_data[k*SLOT_SIZE + SLOT_SIZE - 1 -: SAMPLE_SIZE];
        // Sign-extend one bit so the difference of any max >= min pair cannot overflow.
        assign diff[k] = {max_q[k][SAMPLE_SIZE-1], max_q[k]} - {min_q[k][SAMPLE_SIZE-1], min_q[k]};
    end

    if (DropBits > 0) begin : g_drop
        logic [CHANNELS*DropBits-1:0] unused_lsbs;
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lsb
            assign unused_lsbs[k*DropBits +: DropBits] = i_data[k*SLOT_SIZE +: DropBits];
        end
    end

    assign len_in = (i_windowLength == '0) ? COUNT_SIZE'(1) : i_windowLength;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        max_d     = max_q;
        min_d     = min_q;
        amp_d     = amp_q;
        start_win = 1'b0;
        accept    = 1'b0;
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
        sat_acc_d = sat_acc_q;
        sat_d     = sat_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_enable) begin
                    state_d   = StSample;
                    start_win = 1'b1;
                end
            end
            StSample: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (i_sample) begin
                    accept  = 1'b1;
                    count_d = count_q + COUNT_SIZE'(1);
                    if (count_d == len_q) begin
                        state_d = StDetect;
                    end
                end
            end
            StDetect: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else begin
                    state_d = StUpdate;
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        amp_d[k*AMPLITUDE_DATA_SIZE +: AMPLITUDE_DATA_SIZE] =
                            AMPLITUDE_DATA_SIZE'(diff[k] >> 1);
                    end
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
                    sat_d = sat_acc_q;
`endif
                end
            end
            StUpdate: begin
                if (i_enable) begin
                    state_d   = StSample;
                    start_win = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_win) begin
            len_d   = len_in;
            count_d = '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                max_d[k] = SampleMin;
                min_d[k] = SampleMax;
            end
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
            sat_acc_d = '0;
`endif
        end

        if (accept) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (samp[k] > max_q[k]) max_d[k] = samp[k];
                if (samp[k] < min_q[k]) min_d[k] = samp[k];
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
                if (samp[k] == SampleMax || samp[k] == SampleMin) sat_acc_d[k] = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            amp_q   <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                max_q[k] <= '0;
                min_q[k] <= '0;
            end
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
            sat_acc_q <= '0;
            sat_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            amp_q   <= amp_d;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                max_q[k] <= max_d[k];
                min_q[k] <= min_d[k];
            end
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
            sat_acc_q <= sat_acc_d;
            sat_q     <= sat_d;
`endif
        end
    end

    assign o_amplitude = amp_q;
    assign o_update    = (state_q == StUpdate);
    assign o_busy      = (state_q != StIdle);
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
    assign o_saturated = sat_q;
`endif

endmodule

// File: tb/tb_amplitude_detector_mc.sv
// Directed bench for amplitude_detector_mc (2 channels, 14-bit samples in 16-bit slots).
module tb_amplitude_detector_mc;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_sample = 1'b0;
    logic [15:0] i_windowLength = 16'd4;
    logic [31:0] i_data = '0;
    logic [31:0] o_amplitude;
    logic        o_update;
    logic        o_busy;
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
    logic [1:0]  o_saturated;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    int pre;

    amplitude_detector_mc dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_sample       (i_sample),
        .i_windowLength (i_windowLength),
        .i_data         (i_data),
        .o_amplitude    (o_amplitude),
        .o_update       (o_update),
        .o_busy         (o_busy)
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
        ,
        .o_saturated    (o_saturated)
`endif
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) if (o_update) upd_cnt <= upd_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    function automatic logic [31:0] pack(input int a, input int b);
        logic [15:0] sa, sb;
        sa = 16'(a * 4);
        sb = 16'(b * 4);
        return {sb, sa};
    endfunction

    function automatic logic [31:0] amp(input int c0, input int c1);
        return {16'(c1), 16'(c0)};
    endfunction

    task automatic strobe(input int a, input int b);
        i_sample = 1'b1;
        i_data   = pack(a, b);
        tick();
        i_sample = 1'b0;
    endtask

    // Called one cycle after the last strobe of a window; leaves the bench in the UPDATE cycle.
    task automatic finish(input string tag, input int c0, input int c1);
        check({tag, "_upd_detect"}, {31'd0, o_update}, 32'd0);
        tick();
        check({tag, "_upd"}, {31'd0, o_update}, 32'd1);
        check({tag, "_amp"}, o_amplitude, amp(c0, c1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_amp", o_amplitude, 32'd0);
        check("rst_upd", {31'd0, o_update}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        i_reset  = 1'b0;
        i_enable = 1'b1;
        tick();
        check("start_busy", {31'd0, o_busy}, 32'd1);

        // Basic window.
        strobe(100, 7);
        strobe(-100, 7);
        strobe(50, 7);
        strobe(0, 7);
        finish("basic", 100, 0);
        tick();
        check("basic_single_pulse", {31'd0, o_update}, 32'd0);

        // Reset after 2 of 4 strobes.
        strobe(10, -5);
        strobe(20, -5);
        i_reset = 1'b1;
        #1;
        check("midrst_amp", o_amplitude, 32'd0);
        check("midrst_upd", {31'd0, o_update}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        pre = upd_cnt;
        strobe(10, -5);
        strobe(20, -5);
        strobe(30, -5);
        tick();
        tick();
        check("midrst_no_pulse", 32'(upd_cnt - pre), 32'd0);
        strobe(40, -5);
        finish("midrst", 15, 0);

        // Gapped strobes; strobes held through DETECT/UPDATE must be dropped.
        tick();
        strobe(1, -1000); tick(); tick();
        strobe(3, 1000);  tick(); tick();
        strobe(-2, 0);    tick(); tick();
        i_sample = 1'b1;
        i_data   = pack(4, 0);
        tick();
        i_data   = pack(8000, -8000);
        finish("gap", 3, 1000);
        tick();
        i_sample = 1'b0;
        // Length change mid-window only applies from the next window.
        strobe(5, 2);
        i_windowLength = 16'd0;
        strobe(9, 2);
        strobe(5, 2);
        pre = upd_cnt;
        tick();
        tick();
        check("gap2_no_early", 32'(upd_cnt - pre), 32'd0);
        strobe(5, 2);
        finish("gap2", 2, 0);

        // Zero length behaves as one.
        tick();
        strobe(123, -45);
        finish("len0_a", 0, 0);
        tick();
        strobe(-7, 99);
        finish("len0_b", 0, 0);
        i_windowLength = 16'd4;
        tick();

        // Enable drop after 3 of 4 strobes.
        strobe(0, 0);
        strobe(0, -6);
        strobe(0, 0);
        strobe(20, 0);
        finish("pre_abort", 10, 3);
        tick();
        strobe(-500, 500);
        strobe(500, -500);
        strobe(0, 0);
        i_enable = 1'b0;
        pre = upd_cnt;
        tick();
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        tick();
        tick();
        check("abort_no_pulse", 32'(upd_cnt - pre), 32'd0);
        check("abort_hold", o_amplitude, amp(10, 3));
        i_enable = 1'b1;
        tick();
        strobe(1, 0);
        strobe(2, 0);
        strobe(3, 0);
        strobe(4, 0);
        finish("reen", 1, 0);
        i_windowLength = 16'd2;
        tick();

        // Full-scale swing, then a quiet window.
        strobe(-8192, 0);
        strobe(8191, 0);
        finish("full", 8191, 0);
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
        check("full_sat", {30'd0, o_saturated}, 32'd1);
`endif
        tick();
        strobe(0, 0);
        strobe(1, 0);
        finish("quiet", 0, 0);
`ifdef AMPLITUDE_DETECTOR_SATURATION_FLAG_EN
        check("quiet_sat", {30'd0, o_saturated}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
